// File: rtl/regfile_pkg.sv
// +--------------------------------------------------------------------------+
// | regfile_pkg: opcodes, FSM states and default widths for the register     |
// | file initiator and its bench.                        Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_initiator.sv
// +--------------------------------------------------------------------------+
// | regfile_initiator: one-command-at-a-time sequencer for the 16x32         |
// | register file (WRITE/READ/COPY/ADD).                 Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_initiator
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_addr_d,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              rsp_carry,
  output logic              rf_en,
  output logic              rf_rd,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_sel_i1,
  output logic [ADDR_W-1:0] rf_sel_o1,
  output logic [ADDR_W-1:0] rf_sel_o2,
  output logic [DATA_W-1:0] rf_ip1,
  input  logic [DATA_W-1:0] rf_op1,
  input  logic [DATA_W-1:0] rf_op2
);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_a;
  logic [ADDR_W-1:0]   r_b;
  logic [ADDR_W-1:0]   r_d;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_A;
  logic [DATA_W-1:0]   r_B;
  logic [DATA_W:0]     w_sum;

  assign w_sum = {1'b0, r_A} + {1'b0, r_B};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_data  <= '0;
      r_A     <= '0;
      r_B     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && cmd_valid) begin
        r_op   <= cmd_op;
        r_a    <= cmd_addr_a;
        r_b    <= cmd_addr_b;
        r_d    <= cmd_addr_d;
        r_data <= cmd_data;
      end
      // File read data is registered, so it is valid in the cycle after RD.
      if (r_state == ST_CAP) begin
        r_A <= rf_op1;
        r_B <= rf_op2;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data_a = '0;
    rsp_data_b = '0;
    rsp_carry  = 1'b0;
    rf_en      = 1'b0;
    rf_rd      = 1'b0;
    rf_wr      = 1'b0;
    rf_sel_i1  = '0;
    rf_sel_o1  = '0;
    rf_sel_o2  = '0;
    rf_ip1     = '0;
    case (r_state)
      ST_IDLE: begin
        // Held low while rst is asserted so the port reads 0 during reset.
        cmd_ready = !rst;
        if (cmd_valid) w_next = (cmd_op == OP_WRITE) ? ST_WR : ST_RD;
      end
      ST_RD: begin
        rf_en     = 1'b1;
        rf_rd     = 1'b1;
        rf_sel_o1 = r_a;
        rf_sel_o2 = (r_op == OP_COPY) ? r_a : r_b;
        w_next    = ST_CAP;
      end
      ST_CAP: begin
        w_next = (r_op == OP_READ) ? ST_RESP : ST_WR;
      end
      ST_WR: begin
        rf_en     = 1'b1;
        rf_wr     = 1'b1;
        rf_sel_i1 = r_d;
        case (r_op)
          OP_WRITE: rf_ip1 = r_data;
          OP_ADD:   rf_ip1 = w_sum[DATA_W-1:0];
          default:  rf_ip1 = r_A;
        endcase
        w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        case (r_op)
          OP_WRITE: rsp_data_a = r_data;
          OP_ADD:   rsp_data_a = w_sum[DATA_W-1:0];
          default:  rsp_data_a = r_A;
        endcase
        rsp_data_b = (r_op == OP_READ || r_op == OP_ADD) ? r_B : '0;
        rsp_carry  = (r_op == OP_ADD) && w_sum[DATA_W];
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire
